// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs. buffered out-of-order MDU results.
// Optional pending-register scoreboard is built when RF_ARB_SCOREBOARD_EN is defined.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned REG_MEM_ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH         = 2,
  parameter int unsigned STARVE_LIMIT       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_valid_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]         wb_data_i,
  input  logic                          mdu_valid_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] mdu_addr_i,
  input  logic [DATA_WIDTH-1:0]         mdu_data_i,
  output logic                          mdu_ready_o,
  output logic                          stall_o,
  input  logic                          issue_valid_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] issue_addr_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] chk_addr1_i,
  input  logic [REG_MEM_ADDR_WIDTH-1:0] chk_addr2_i,
  output logic                          chk_busy1_o,
  output logic                          chk_busy2_o,
  output logic                          rf_wr_en_o,
  output logic [REG_MEM_ADDR_WIDTH-1:0] rf_wr_addr_o,
  output logic [DATA_WIDTH-1:0]         rf_wr_data_o
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W    = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NUM_REGS = 1 << REG_MEM_ADDR_WIDTH;

  typedef struct packed {
    logic [REG_MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]         data;
  } mdu_entry_t;

  mdu_entry_t       mem_q [FIFO_DEPTH];
  mdu_entry_t       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic       fifo_empty;
  logic       fifo_full;
  logic       starved;
  logic       wb_live;
  logic       grant_head;
  logic       grant_wb;
  logic       mdu_ready;
  logic       push;
  mdu_entry_t head;

  // Arbitration: a starved head beats the pipeline; otherwise the pipeline wins.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    starved    = (starve_q == STV_W'(STARVE_LIMIT));
    head       = mem_q[rd_ptr_q];
    wb_live    = wb_valid_i && (wb_addr_i != '0);
    grant_head = !rst && !fifo_empty && (starved || !wb_live);
    grant_wb   = !rst && wb_live && !starved;
    mdu_ready  = !rst && !fifo_full;
    push       = mdu_valid_i && mdu_ready && (mdu_addr_i != '0);
  end

  always_comb begin
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = '0;
    rf_wr_data_o = '0;
    if (grant_head) begin
      rf_wr_en_o   = 1'b1;
      rf_wr_addr_o = head.addr;
      rf_wr_data_o = head.data;
    end else if (grant_wb) begin
      rf_wr_en_o   = 1'b1;
      rf_wr_addr_o = wb_addr_i;
      rf_wr_data_o = wb_data_i;
    end
  end

  assign mdu_ready_o = mdu_ready;
  assign stall_o     = !rst && starved;

  // FIFO and starvation counter next state; ready ignores a same-cycle pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = starve_q;
    if (push) begin
      mem_d[wr_ptr_q].addr = mdu_addr_i;
      mem_d[wr_ptr_q].data = mdu_data_i;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (grant_head) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(grant_head);
    if (fifo_empty || grant_head) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q, pending_d;

  // A new issue to the same register outranks the retiring head write.
  always_comb begin
    pending_d = pending_q;
    if (grant_head) begin
      pending_d[head.addr] = 1'b0;
    end
    if (issue_valid_i && (issue_addr_i != '0)) begin
      pending_d[issue_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign chk_busy1_o = !rst && pending_q[chk_addr1_i] && (chk_addr1_i != '0);
  assign chk_busy2_o = !rst && pending_q[chk_addr2_i] && (chk_addr2_i != '0);
`else
  logic unused_sb;

  assign unused_sb   = ^{issue_valid_i, issue_addr_i, chk_addr1_i, chk_addr2_i, NUM_REGS[0]};
  assign chk_busy1_o = 1'b0;
  assign chk_busy2_o = 1'b0;
`endif

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and a long-latency unit (MDU: multiply/divide) that completes out of order. MDU results are buffered in a small FIFO and drained into idle write-port cycles. A starvation guard stalls the pipeline when a buffered result has waited too long. An optional scoreboard tracks destination registers with an MDU result still outstanding, for ID-stage hazard detection. Sits between the EX/WB stages and the register file's write port.

## Interface
- DATA_WIDTH, 32, register data width
- REG_MEM_ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_o asserts (≥1)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid_i  in  1  pipeline writeback request
- wb_addr_i  in  REG_MEM_ADDR_WIDTH  pipeline destination
- wb_data_i  in  DATA_WIDTH  pipeline result
- mdu_valid_i  in  1  MDU result valid
- mdu_addr_i  in  REG_MEM_ADDR_WIDTH  MDU destination
- mdu_data_i  in  DATA_WIDTH  MDU result
- mdu_ready_o  out  1  FIFO can accept an MDU result
- stall_o  out  1  pipeline must hold its WB stage this cycle
- issue_valid_i  in  1  MDU op issued (scoreboard set)
- issue_addr_i  in  REG_MEM_ADDR_WIDTH  destination of the issued op
- chk_addr1_i, chk_addr2_i  in  REG_MEM_ADDR_WIDTH  ID source indices
- chk_busy1_o, chk_busy2_o  out  1  source has an MDU result pending
- rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o  out  1/REG_MEM_ADDR_WIDTH/DATA_WIDTH  to register file write port

## Operation
- The pipeline request is live when wb_valid_i=1 and wb_addr_i≠0. A request with wb_addr_i=0 produces no write and leaves the port free.
- Grant priority:
  - stall_o=1: grant the FIFO head.
  - Otherwise, a live pipeline request wins.
  - Otherwise, grant the FIFO head if the FIFO is non-empty.
- While stall_o=1, the pipeline request is not written; the pipeline re-presents it next cycle.
- MDU push occurs when mdu_valid_i && mdu_ready_o. Pushes with mdu_addr_i=0 are accepted but not stored.
- mdu_ready_o = !full. It does not account for a same-cycle pop.
- Push and pop may occur in the same cycle. The FIFO preserves order.
- Starve counter:
  - Clears on reset, on a head grant, and whenever the FIFO is empty.
  - Increments each cycle the FIFO is non-empty and the head is not granted, saturating at STARVE_LIMIT.
  - stall_o = (count == STARVE_LIMIT).
- Scoreboard (one pending bit per register):
  - issue_valid_i with a non-zero address sets the bit.
  - A FIFO head write to the register file clears the bit for that address.
  - Set and clear of the same address in the same cycle: set wins.
  - chk_busyN_o = pending[chk_addrN_i] && chk_addrN_i≠0.

## Timing
- rf_wr_* and stall_o are combinational from wb_* and registered state. No path runs from wb_* to stall_o.
- MDU result to register file: minimum 1 cycle (push at edge N, write during cycle N+1). No bypass from mdu_* to rf_wr_*.
- Scoreboard bits update at the edge; chk_busy*_o reflects them combinationally from chk_addr*_i.
- During rst and after reset:
  - FIFO is empty, counter = 0, pending bits all 0.
  - rf_wr_en_o=0, mdu_ready_o=0 while rst=1 (1 after release), stall_o=0, chk_busy*_o=0.
  - rf_wr_addr_o and rf_wr_data_o read 0 when rf_wr_en_o=0.
- Reset mid-operation discards buffered results and pending bits.
- Worst-case wait of a FIFO head from reaching the head to its write: STARVE_LIMIT+1 cycles.

## Configuration
- RF_ARB_SCOREBOARD_EN defined: the scoreboard is built as described above.
- Not defined:
  - No pending storage is built.
  - issue_* and chk_addr*_i are ignored.
  - chk_busy1_o = chk_busy2_o = 0 constantly.
  - All other behaviour is unchanged.

## Test plan
- Reset, then idle: all outputs 0, mdu_ready_o=1 one cycle after rst falls.
- Port contention: mdu push x5=0x11 at cycle 0, wb x3=0x22 on cycles 1–2.
  - Cycles 1–2: the port writes x3.
  - Cycle 3 (wb idle): the port writes x5=0x11.
- Starvation: push x7=0xAA, then hold wb_valid_i=1 to x1.
  - stall_o rises after 4 ungranted cycles.
  - That cycle, x7 is written and x1 is not.
  - stall_o=0 next cycle.
- Full FIFO: push x4, x6 with wb busy. mdu_ready_o=0; a third mdu_valid_i is not accepted. One drain cycle restores mdu_ready_o=1.
- x0 handling: wb_valid_i to x0 leaves rf_wr_en_o=0 and lets the FIFO drain. An MDU push to x0 leaves the FIFO empty.
- Scoreboard (macro defined):
  - Issue x9: chk_busy1_o=1 for chk_addr1_i=9.
  - Cleared the cycle after x9 is written from the FIFO.
  - Re-issuing x9 in the write cycle keeps it at 1.
